// File: rtl/psram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psram_ctrl_pkg
// Description : Shared types and constants for the async PSRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
package psram_ctrl_pkg;

  localparam int c_ACCESS_CYCLES = 8;
  localparam int c_TURN_CYCLES   = 2;
  localparam int c_ADDR_W        = 23;
  localparam int c_DATA_W        = 16;
  localparam int c_BE_W          = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/psram_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : psram_rr_arb2
// Description : Two-way round-robin arbiter; last_grant updates on i_take.
// Revision    : 1.0 - initial release
// ============================================================================
module psram_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic       o_any,
  output logic       o_gnt
);

  logic r_last;

  always_comb begin
    o_any = |i_req;
    o_gnt = (&i_req) ? ~r_last : i_req[1];
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_take) begin
      r_last <= o_gnt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/psram_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : psram_arb_ctrl
// Description : Two-requester arbiter and asynchronous-mode PSRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
module psram_arb_ctrl
  import psram_ctrl_pkg::*;
#(
  parameter int ACCESS_CYCLES = c_ACCESS_CYCLES,
  parameter int TURN_CYCLES   = c_TURN_CYCLES
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic                m0_we,
  input  logic [c_ADDR_W-1:0] m0_addr,
  input  logic [c_DATA_W-1:0] m0_wdata,
  input  logic [c_BE_W-1:0]   m0_be,
  output logic [c_DATA_W-1:0] m0_rdata,
  output logic                m0_rvalid,
  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic                m1_we,
  input  logic [c_ADDR_W-1:0] m1_addr,
  input  logic [c_DATA_W-1:0] m1_wdata,
  input  logic [c_BE_W-1:0]   m1_be,
  output logic [c_DATA_W-1:0] m1_rdata,
  output logic                m1_rvalid,
  output logic [c_ADDR_W-1:0] psram_addr,
  output logic                psram_ce_n,
  output logic                psram_oen,
  output logic                psram_wen,
  output logic                psram_adv_ldn,
  output logic                psram_cre,
  output logic [c_BE_W-1:0]   psram_ben,
  inout  wire  [c_DATA_W-1:0] psram_dq_io
);

  localparam int c_CNT_MAX = (ACCESS_CYCLES > TURN_CYCLES) ? ACCESS_CYCLES : TURN_CYCLES;
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
  localparam logic [c_CNT_W-1:0] c_ACC_LAST  = c_CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TURN_LAST = c_CNT_W'(TURN_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;

  logic [1:0]           w_req;
  logic                 w_any;
  logic                 w_gnt;
  logic                 w_take;
  logic                 w_in_acc;
  logic                 w_rd_done;

  logic [c_ADDR_W-1:0]  w_sel_addr;
  logic [c_DATA_W-1:0]  w_sel_wdata;
  logic [c_BE_W-1:0]    w_sel_be;
  logic                 w_sel_we;

  logic [c_ADDR_W-1:0]  r_addr;
  logic [c_DATA_W-1:0]  r_wdata;
  logic [c_BE_W-1:0]    r_be;
  logic                 r_we;
  logic                 r_gnt;
  logic [1:0]           r_ready;
  logic [1:0]           r_rvalid;
  logic [c_DATA_W-1:0]  r_rdata0;
  logic [c_DATA_W-1:0]  r_rdata1;
  logic                 r_ce_n;
  logic                 r_oen;
  logic                 r_wen;
  logic [c_BE_W-1:0]    r_ben;
  logic                 r_dq_oe;

  assign w_req  = {m1_valid, m0_valid};
  assign w_take = (r_state == IDLE) && w_any;

  psram_rr_arb2 u_arb (
    .clk    (sys_clk),
    .rst_n  (sys_rst),
    .i_req  (w_req),
    .i_take (w_take),
    .o_any  (w_any),
    .o_gnt  (w_gnt)
  );

  assign w_sel_addr  = w_gnt ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_gnt ? m1_wdata : m0_wdata;
  assign w_sel_be    = w_gnt ? m1_be    : m0_be;
  assign w_sel_we    = w_gnt ? m1_we    : m0_we;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = '0;
        end
      end
      ACCESS: begin
        if (r_cnt == c_ACC_LAST) begin
          w_state_nxt = TURN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      TURN: begin
        if (r_cnt == c_TURN_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_gnt   <= 1'b0;
      r_ready <= 2'b00;
    end else begin
      r_ready <= w_take ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
      if (w_take) begin
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_be    <= w_sel_be;
        r_we    <= w_sel_we;
        r_gnt   <= w_gnt;
      end
    end
  end

  // Strobes lag the state by one cycle, so CE_n is low for T+1..T+ACCESS_CYCLES.
  assign w_in_acc  = (r_state == ACCESS);
  assign w_rd_done = (r_state == TURN) && (r_cnt == '0) && !r_we;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_ce_n  <= 1'b1;
      r_oen   <= 1'b1;
      r_wen   <= 1'b1;
      r_ben   <= 2'b11;
      r_dq_oe <= 1'b0;
    end else begin
      r_ce_n  <= ~w_in_acc;
      r_oen   <= ~(w_in_acc & ~r_we);
      r_wen   <= ~(w_in_acc & r_we & (r_cnt != c_ACC_LAST));
      r_ben   <= w_in_acc ? ~r_be : 2'b11;
      r_dq_oe <= w_in_acc & r_we;
    end
  end

  // dq is captured at the end of the last CE_n-low cycle.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_rvalid <= 2'b00;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_rvalid <= w_rd_done ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
      if (w_rd_done && !r_gnt) begin
        r_rdata0 <= psram_dq_io;
      end
      if (w_rd_done && r_gnt) begin
        r_rdata1 <= psram_dq_io;
      end
    end
  end

  assign psram_dq_io   = r_dq_oe ? r_wdata : {c_DATA_W{1'bz}};
  assign psram_addr    = r_addr;
  assign psram_ce_n    = r_ce_n;
  assign psram_oen     = r_oen;
  assign psram_wen     = r_wen;
  assign psram_ben     = r_ben;
  assign psram_adv_ldn = 1'b0;
  assign psram_cre     = 1'b0;

  assign m0_ready  = r_ready[0];
  assign m1_ready  = r_ready[1];
  assign m0_rvalid = r_rvalid[0];
  assign m1_rvalid = r_rvalid[1];
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;

endmodule
`default_nettype wire
